// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the VGA timing generator to pixel/fetch logic
// The generator is the master. Consumers take the slave side and may own enable.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             enable;
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             hSync;
  logic             vSync;
  logic             videoOn;
  logic             pixTick;
  logic             lineEnd;
  logic             frameStart;

  modport master (
    input  enable,
    output hCount, vCount, hSync, vSync, videoOn, pixTick, lineEnd, frameStart
  );

  modport slave (
    output enable,
    input  hCount, vCount, hSync, vSync, videoOn, pixTick, lineEnd, frameStart
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Prescaled pixel tick drives horizontal and vertical counters. Sync and video decodes are zero-latency.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CNT_W    = 10
) (
  input logic              Clk,
  input logic              vgaRes,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] divCnt;
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             frameStartQ;
  logic             pixTick;
  logic             hLast;
  logic             vLast;
  logic             hSyncOn;
  logic             vSyncOn;

  assign pixTick = vga.enable && (divCnt == DIV_LAST);
  assign hLast   = (hCount == H_LAST);
  assign vLast   = (vCount == V_LAST);
  assign hSyncOn = (hCount >= H_SYNC_BEG) && (hCount < H_SYNC_END);
  assign vSyncOn = (vCount >= V_SYNC_BEG) && (vCount < V_SYNC_END);

  always_ff @(posedge Clk) begin
    if (vgaRes) begin
      divCnt      <= '0;
      hCount      <= '0;
      vCount      <= '0;
      frameStartQ <= 1'b0;
    end else begin
      // Flags the tick that wraps the whole raster, so the strobe lines up with counts (0,0).
      frameStartQ <= pixTick && hLast && vLast;
      if (vga.enable) begin
        divCnt <= pixTick ? '0 : divCnt + DIV_W'(1);
        if (pixTick) begin
          if (hLast) begin
            hCount <= '0;
            vCount <= vLast ? '0 : vCount + CNT_W'(1);
          end else begin
            hCount <= hCount + CNT_W'(1);
          end
        end
      end
    end
  end

  assign vga.hCount     = hCount;
  assign vga.vCount     = vCount;
  assign vga.hSync      = hSyncOn ? H_POL : ~H_POL;
  assign vga.vSync      = vSyncOn ? V_POL : ~V_POL;
  assign vga.videoOn    = (hCount < H_VIS) && (vCount < V_VIS);
  assign vga.pixTick    = pixTick;
  assign vga.lineEnd    = pixTick && hLast;
  // A paused generator emits no strobes, even if the frame flag was set just before the pause.
  assign vga.frameStart = frameStartQ && vga.enable;

endmodule
